pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed-field decode-to-execute stage register.
- Generic pipeline stage carrying a WIDTH-bit packed payload under valid/ready flow control, with a one-entry skid buffer so `in_ready` is a registered signal.
- Synchronous flush squashes in-flight entries and zeroes a configurable control-field mask; saturating stall/bubble counters support performance analysis.
- Instantiated between any two pipeline stages (Fetch/Decode, Decode/Execute, Execute/Memory) in place of hand-written stage registers.

Parameters:
- WIDTH, 128, payload width in bits.
- CTRL_MASK, {WIDTH{1'b1}}, bit i = 1 → payload bit i is forced to 0 on flush/reset (control fields such as RegW, MemW, branch); bit i = 0 → bit holds its value on flush.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept; registered
- in_data  in  WIDTH  upstream payload
- flush  in  1  synchronous squash of all held entries
- out_valid  out  1  downstream entry valid
- out_ready  in  1  downstream accepts
- out_data  out  WIDTH  payload of the oldest held entry (main register)
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating
- bubble_cnt  out  CNT_W  cycles with out_valid=0 and flush=0, saturating

Behaviour:
- Storage: main register (main_data, main_v) and skid register (skid_data, skid_v).
- `out_data` = main_data; `out_valid` = main_v. No combinational path from any input to any output.
- State encoding {skid_v, main_v}:
  - EMPTY = 00
  - ONE = 01
  - TWO = 11
  - 10 is illegal and must never occur.
- in_ready = ~skid_v, registered, so it deasserts the cycle after the stage reaches TWO.
- Accept = in_valid & in_ready; Drain = out_valid & out_ready.
- Transitions when flush=0:
  - EMPTY, Accept → ONE; main ← in_data. Latency: entry is visible on out_data the cycle after acceptance.
  - ONE, Accept & Drain → ONE; main ← in_data.
  - ONE, Accept & ~Drain → TWO; skid ← in_data, main holds.
  - ONE, ~Accept & Drain → EMPTY.
  - TWO, Drain → ONE; main ← skid, skid_v ← 0. Accept is impossible because in_ready=0.
  - TWO, ~Drain → TWO; everything holds.
  - Any other combination → state and data hold.
- Ordering: entries leave in acceptance order. No entry is duplicated or dropped except by flush.
- Flush (flush=1), evaluated in the same cycle and taking priority over Accept and Drain:
  - main_v ← 0, skid_v ← 0, next state EMPTY.
  - An input handshaked in the flush cycle is discarded.
  - A Drain in the flush cycle is still a completed handshake for downstream. Downstream is responsible for qualifying it with flush.
  - main_data and skid_data bits with CTRL_MASK=1 ← 0; bits with CTRL_MASK=0 hold.
  - in_ready = 1 the following cycle.
- Reset (priority over flush):
  - main_v, skid_v, main_data, skid_data and both counters ← 0.
  - in_ready ← 1.
  - Reset asserted mid-operation discards all entries with no partial state.
- Counters:
  - Increment by 1 per qualifying cycle and saturate at 2^CNT_W−1, with no wrap.
  - Unaffected by flush.
  - stall_cnt counts in TWO and ONE states alike.
  - The flush cycle itself does not count as a bubble.
- Width rules: payload is passed bit-exact. CTRL_MASK is applied bitwise and has no effect when flush=0.

Test Plan:
- Reset then idle 5 cycles → out_valid=0, out_data=0, in_ready=1, bubble_cnt=5, stall_cnt=0.
- Stream in_data=0x1,0x2,0x3 back-to-back with out_ready=1 → out_data=0x1,0x2,0x3 on the 3 cycles after each accept; in_ready stays 1; state never reaches TWO.
- Backpressure: out_ready=0, push 0xA then 0xB → state TWO, in_ready=0 from the next cycle; hold out_ready=0 for 4 cycles → stall_cnt increments each cycle out_valid=1 and out_ready=0 (last accept cycle included); raise out_ready → 0xA then 0xB emitted in order; in_ready=1 the cycle after 0xA drains.
- Flush in TWO with CTRL_MASK=0x00FF (WIDTH=16), entries 0x1234/0x5678 → next cycle out_valid=0, in_ready=1, main_data=0x1200; in_valid=1 during the flush cycle is not emitted.
- Simultaneous Accept & Drain in ONE for 10 cycles with incrementing data → throughput 1 per cycle, no reordering, no entry lost.
- CNT_W=3, keep empty 10 cycles → bubble_cnt saturates at 7; reset asserted mid-stream in TWO → all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
//   Generic valid/ready pipeline stage with a one-entry skid buffer. The
//   upstream ready is a function of flops only, which breaks the ready chain
//   between stages. A synchronous flush squashes held entries and zeroes the
//   control bits selected by CTRL_MASK. Two saturating counters report stall
//   cycles and bubble cycles.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     upstream handshake (in_ready is registered)
//   in_data               upstream payload, WIDTH bits
//   flush                 squash all held entries this cycle
//   out_valid/out_ready   downstream handshake
//   out_data              payload of the oldest entry (main register)
//   stall_cnt             cycles with out_valid=1, out_ready=0 (saturating)
//   bubble_cnt            cycles with out_valid=0, flush=0 (saturating)
module pipe_stage_skid #(
    parameter int               WIDTH     = 128,
    parameter logic [WIDTH-1:0] CTRL_MASK = {WIDTH{1'b1}},
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    // Encoding is {skid_v, main_v}; 2'b10 is unreachable.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b11
    } state_t;

    state_t           r_state;
    state_t           w_nxt_state;
    logic [WIDTH-1:0] r_main_data;
    logic [WIDTH-1:0] r_skid_data;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    logic w_main_v;
    logic w_skid_v;
    logic w_accept;
    logic w_drain;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;

    assign w_main_v = r_state[0];
    assign w_skid_v = r_state[1];
    assign w_accept = in_valid & ~w_skid_v;
    assign w_drain  = w_main_v & out_ready;

    always_comb begin
        w_nxt_state      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_nxt_state    = ONE;
                    w_load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (w_accept && w_drain) begin
                    w_load_main_in = 1'b1;
                end else if (w_accept) begin
                    w_nxt_state = TWO;
                    w_load_skid = 1'b1;
                end else if (w_drain) begin
                    w_nxt_state = EMPTY;
                end
            end
            TWO: begin
                // in_ready is low here, so only a drain can move the state.
                if (w_drain) begin
                    w_nxt_state      = ONE;
                    w_load_main_skid = 1'b1;
                end
            end
            default: w_nxt_state = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= EMPTY;
            r_main_data  <= '0;
            r_skid_data  <= '0;
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (flush) begin
                // Flush wins over any accept/drain; control bits are cleared
                // so a squashed entry can never look like a live instruction.
                r_state     <= EMPTY;
                r_main_data <= r_main_data & ~CTRL_MASK;
                r_skid_data <= r_skid_data & ~CTRL_MASK;
            end else begin
                r_state <= w_nxt_state;
                if (w_load_main_in)
                    r_main_data <= in_data;
                else if (w_load_main_skid)
                    r_main_data <= r_skid_data;
                if (w_load_skid)
                    r_skid_data <= in_data;
            end

            if (w_main_v && !out_ready && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (!w_main_v && !flush && (r_bubble_cnt != '1))
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
    end

    assign in_ready   = ~w_skid_v;
    assign out_valid  = w_main_v;
    assign out_data   = r_main_data;
    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid (WIDTH=16, CTRL_MASK=16'h00FF, CNT_W=3).
// Per-cycle vector table with expected outputs, a scoreboard queue that
// tracks accepted payloads against drained ones, and hand-written reset and
// saturation sequences.
module tb_pipe_stage_skid;

    localparam int WIDTH = 16;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] bubble_cnt;

    pipe_stage_skid #(
        .WIDTH    (WIDTH),
        .CTRL_MASK(16'h00FF),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_drained = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: accepted payloads are queued, drained ones must match the
    // head of the queue. Flush and reset discard everything held.
    logic [WIDTH-1:0] sb_q[$];
    always @(posedge clk) begin
        if (reset || flush) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_drained++;
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_drain", {16'h0, out_data}, 32'hFFFF_FFFF);
                end else begin
                    chk("sb_order", {16'h0, out_data}, {16'h0, sb_q.pop_front()});
                end
            end
            if (in_valid && in_ready)
                sb_q.push_back(in_data);
        end
    end

    typedef struct {
        logic             iv;
        logic [WIDTH-1:0] d;
        logic             ordy;
        logic             fl;
        logic             ov;
        logic [WIDTH-1:0] od;
        logic             ir;
        logic [CNT_W-1:0] stl;
        logic [CNT_W-1:0] bub;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic iv, input logic [15:0] d, input logic ordy,
                                input logic fl, input logic ov, input logic [15:0] od,
                                input logic ir, input logic [2:0] stl, input logic [2:0] bub);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
        v.ov = ov; v.od = od; v.ir = ir; v.stl = stl; v.bub = bub;
        tbl.push_back(v);
    endfunction

    task automatic chk_all(input string tag, input logic ov, input logic [15:0] od,
                           input logic ir, input logic [2:0] stl, input logic [2:0] bub);
        chk({tag, "_out_valid"}, {31'h0, out_valid}, {31'h0, ov});
        chk({tag, "_out_data"}, {16'h0, out_data}, {16'h0, od});
        chk({tag, "_in_ready"}, {31'h0, in_ready}, {31'h0, ir});
        chk({tag, "_stall_cnt"}, {29'h0, stall_cnt}, {29'h0, stl});
        chk({tag, "_bubble_cnt"}, {29'h0, bubble_cnt}, {29'h0, bub});
    endtask

    initial begin
        //   iv  data     ordy fl   ov  out_data ir  stl  bub
        // streaming, no backpressure
        add(1, 16'h0001, 1, 0,  1, 16'h0001, 1, 0, 1);
        add(1, 16'h0002, 1, 0,  1, 16'h0002, 1, 0, 1);
        add(1, 16'h0003, 1, 0,  1, 16'h0003, 1, 0, 1);
        add(0, 16'h0000, 1, 0,  0, 16'h0003, 1, 0, 1);
        // backpressure: A then B fill to TWO, stall 4 cycles, then drain
        add(1, 16'h000A, 0, 0,  1, 16'h000A, 1, 0, 2);
        add(1, 16'h000B, 0, 0,  1, 16'h000A, 0, 1, 2);
        add(1, 16'h000C, 0, 0,  1, 16'h000A, 0, 2, 2);
        add(1, 16'h000C, 0, 0,  1, 16'h000A, 0, 3, 2);
        add(1, 16'h000C, 0, 0,  1, 16'h000A, 0, 4, 2);
        add(0, 16'h0000, 1, 0,  1, 16'h000B, 1, 4, 2);
        add(0, 16'h0000, 1, 0,  0, 16'h000B, 1, 4, 2);
        // flush in TWO with an input offered in the flush cycle
        add(1, 16'h1234, 0, 0,  1, 16'h1234, 1, 4, 3);
        add(1, 16'h5678, 0, 0,  1, 16'h1234, 0, 5, 3);
        add(1, 16'h9999, 0, 1,  0, 16'h1200, 1, 6, 3);
        add(0, 16'h0000, 1, 0,  0, 16'h1200, 1, 6, 4);
        add(0, 16'h0000, 1, 1,  0, 16'h1200, 1, 6, 4);
        // 1-per-cycle throughput: accept and drain together in ONE
        add(1, 16'h0100, 1, 0,  1, 16'h0100, 1, 6, 5);
        for (int i = 1; i <= 10; i++)
            add(1, 16'(16'h0100 + i), 1, 0,  1, 16'(16'h0100 + i), 1, 6, 5);
        add(0, 16'h0000, 1, 0,  0, 16'h010A, 1, 6, 5);
        // stall counter saturation, ending in TWO
        add(1, 16'h0055, 0, 0,  1, 16'h0055, 1, 6, 6);
        add(0, 16'h0000, 0, 0,  1, 16'h0055, 1, 7, 6);
        add(0, 16'h0000, 0, 0,  1, 16'h0055, 1, 7, 6);
        add(1, 16'h0066, 0, 0,  1, 16'h0055, 0, 7, 6);

        reset = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_all("reset", 0, 16'h0000, 1, 0, 0);
        reset = 1'b0;

        repeat (5) @(negedge clk);
        chk_all("idle5", 0, 16'h0000, 1, 0, 5);
        repeat (5) @(negedge clk);
        chk("bubble_sat", {29'h0, bubble_cnt}, 32'd7);

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_drained = 0;

        foreach (tbl[i]) begin
            in_valid  = tbl[i].iv;
            in_data   = tbl[i].d;
            out_ready = tbl[i].ordy;
            flush     = tbl[i].fl;
            @(negedge clk);
            chk_all($sformatf("vec%0d", i), tbl[i].ov, tbl[i].od, tbl[i].ir,
                    tbl[i].stl, tbl[i].bub);
        end
        chk("drain_count", n_drained, 32'd16);
        chk("sb_pending", sb_q.size(), 32'd2);

        // reset while in TWO
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; reset = 1'b1;
        @(negedge clk);
        chk_all("reset_in_two", 0, 16'h0000, 1, 0, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_idle_bubble", {29'h0, bubble_cnt}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
